md5_block_sched: RTL and testbench
==================================

Name: md5_block_sched

Overview:
- Message-level sequencer between host block stream, md5_padding unit and MD5 compression core.
- Accepts 512-bit message blocks and tracks the 64-bit running bit length.
- Forwards full blocks straight to the core; routes the final block through the padding unit, including the 2-block (WAIT/resume) case.
- Presents the core with an ordered block stream tagged first/last, and pulses msg_done when the final padded block is accepted.

Parameters:
- LEN_W, 64, running-length counter width; fixed by MD5 length field.
- SETTLE, 2, cycles pad_done/pad_waiting are ignored after pad_start (stale-done window).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- blk_valid  in  1  host block valid
- blk_ready  out  1  controller accepts block
- blk_data  in  512  block, bit 0 = first message bit ([0:511] ordering)
- blk_last  in  1  final block of message
- blk_bits  in  10  valid bits in block (0..512); must be 512 when blk_last=0
- pad_start  out  1  padding start pulse
- pad_resume  out  1  padding resume pulse
- pad_input_data  out  512  masked final data to padder
- pad_input_size  out  64  total message length in bits
- pad_padded_data  in  512  padder output
- pad_waiting  in  1  padder needs second block
- pad_done  in  1  padder complete (level, stale until next copy)
- core_valid  out  1  block for core valid
- core_ready  in  1  core accepts block
- core_block  out  512  block to core
- core_first  out  1  block is first of message (core reloads IV)
- core_last  out  1  block is last of message
- msg_done  out  1  one-cycle pulse, message fully issued
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0 except blk_ready=1; length=0; first_flag=1.
- Handshakes are valid/ready; transfer on the cycle both are high. blk_ready=1 only in IDLE. core_valid, core_block, core_first and core_last are held stable until core_ready.
- IDLE on block accept: length += blk_bits (mod 2^64).
  - blk_last=0 -> FWD.
  - blk_last=1 and blk_bits=512 -> FWD, then the pad sequence on zero data.
  - blk_last=1 and blk_bits<512 -> PAD_START.
- FWD: core_block=blk_data (registered); core_first=first_flag; core_last=0. On accept, first_flag<=0, then IDLE or PAD_START (512-bit last).
- PAD_START: pad_start=1 for 1 cycle; pad_input_size=length, held constant through the pad sequence. pad_input_data = captured data with bits [blk_bits..511] forced 0 (all zero in the 512-bit-last case). Go to PAD_WAIT.
- PAD_WAIT: ignore pad inputs for SETTLE cycles, then:
  - pad_done=1 -> SEND_LAST.
  - pad_waiting=1 -> SEND_MID.
  - pad_done has priority if both are high.
- SEND_MID: core_block=pad_padded_data; core_first=first_flag; core_last=0. On accept, first_flag<=0 -> RESUME.
- RESUME: pad_resume=1 for 1 cycle -> PAD_WAIT2.
- PAD_WAIT2: wait pad_done=1 (no settle needed; done cleared earlier) -> SEND_LAST.
- SEND_LAST: core_block=pad_padded_data; core_first=first_flag; core_last=1. On accept -> DONE.
- DONE: msg_done=1 for 1 cycle; length<=0; first_flag<=1 -> IDLE.
- Empty message (first block blk_last=1, blk_bits=0): one padded block with first=last=1.
- core_ready low stalls any SEND/FWD state indefinitely; no timeout.
- Reset mid-operation: immediate return to reset values; the padder is reset by the same rst_n.

Optional Feature:
- Macro MD5_SCHED_LEN_CHECK_EN.
- When defined, err is set (sticky until reset) on any of:
  - an accepted block with blk_bits>512;
  - blk_last=0 with blk_bits!=512;
  - length addition overflow.
- A block that triggers err is still processed with blk_bits clamped to 512.
- When undefined, err is tied 0 and no check logic is built.

Decomposition:
- Package md5_pkg: state encoding enum, BLOCK_W=512, LEN_W=64, PAD_THRESH=440 constant.
- Sub-module md5_tail_mask: combinational 512-bit mask from a 10-bit bit count. It is the only natural split; everything else stays in one FSM.

Test Plan:
- Empty message, blk_last=1, blk_bits=0 -> one core block with bit0=1, rest 0, first=last=1; msg_done pulse.
- "abc" (24 bits, garbage above bit 23) -> one block.
  - Bits 0..23 = data, bit24=1, bits 25..447 = 0.
  - Length field = byte-swapped 24.
  - first=last=1.
- 448-bit last block -> two core blocks: data+bit448 (first=1, last=0); then length-only block (last=1); pad_resume pulsed exactly once.
- 2 full blocks then last with blk_bits=512 -> 4 core blocks (pad block bit0=1, length 1536); first only on block 1.
- core_ready held 0 for 10 cycles during SEND_MID -> core_block stable; no pad_resume until accept.
- rst_n asserted in PAD_WAIT2 -> all outputs at reset values same cycle; a new message afterwards has core_first=1 and length restarting from 0.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 message block scheduler.
// Consumed by md5_block_sched and md5_tail_mask.
package md5_pkg;

    localparam int BLOCK_W    = 512;
    localparam int LEN_W      = 64;
    localparam int PAD_THRESH = 440;
    localparam int SETTLE_CYC = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FWD,
        S_PAD_START,
        S_PAD_WAIT,
        S_SEND_MID,
        S_RESUME,
        S_PAD_WAIT2,
        S_SEND_LAST,
        S_DONE
    } state_e;

endpackage

// File: rtl/md5_tail_mask.sv
// Keeps the first bits_i message bits of a block (bit 0 = first bit).
// Counts of 512 or more give an all-ones mask.
module md5_tail_mask
    import md5_pkg::*;
(
    input  logic [9:0]         bits_i,
    output logic [BLOCK_W-1:0] mask_o
);

    always_comb begin
        for (int i = 0; i < BLOCK_W; i++) begin
            mask_o[i] = (10'(i) < bits_i);
        end
    end

endmodule

// File: rtl/md5_block_sched.sv
// Sequences host blocks and md5_padding output into an ordered core stream.
// Define MD5_SCHED_LEN_CHECK_EN to build the sticky length/protocol err flag.
module md5_block_sched
    import md5_pkg::*;
#(
    parameter int SETTLE = SETTLE_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    input  logic               blk_last,
    input  logic [9:0]         blk_bits,
    output logic               pad_start,
    output logic               pad_resume,
    output logic [BLOCK_W-1:0] pad_input_data,
    output logic [LEN_W-1:0]   pad_input_size,
    input  logic [BLOCK_W-1:0] pad_padded_data,
    input  logic               pad_waiting,
    input  logic               pad_done,
    output logic               core_valid,
    input  logic               core_ready,
    output logic [BLOCK_W-1:0] core_block,
    output logic               core_first,
    output logic               core_last,
    output logic               msg_done,
    output logic               err
);

    localparam int CW = $clog2(SETTLE + 2);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [9:0]         bits_q, bits_d;
    logic               first_q, first_d;
    logic               full_q, full_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [9:0]         bits_eff;
    logic [LEN_W-1:0]   len_sum;
    logic [BLOCK_W-1:0] mask_w;
    logic               short_w;

`ifdef MD5_SCHED_LEN_CHECK_EN
    logic [LEN_W:0] sum_w;
    logic           err_q, err_d;
    logic           bad_w;

    assign bits_eff = (blk_bits > 10'd512) ? 10'd512 : blk_bits;
    assign sum_w    = {1'b0, len_q} + (LEN_W + 1)'(bits_eff);
    assign len_sum  = sum_w[LEN_W-1:0];
    assign bad_w    = (blk_bits > 10'd512)
                   || (!blk_last && blk_bits != 10'd512)
                   || sum_w[LEN_W];

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && blk_valid && bad_w) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign bits_eff = blk_bits;
    assign len_sum  = len_q + LEN_W'(blk_bits);
    assign err      = 1'b0;
`endif

    assign short_w = (bits_eff < 10'd512);

    md5_tail_mask u_mask (
        .bits_i (bits_q),
        .mask_o (mask_w)
    );

    // bits_q is zeroed after a 512-bit last block, so the padder sees no data.
    assign pad_input_data = data_q & mask_w;
    assign pad_input_size = len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            data_q  <= '0;
            bits_q  <= '0;
            first_q <= 1'b1;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
            first_q <= first_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    state_d = (blk_last && short_w) ? S_PAD_START : S_FWD;
                end
            end
            S_FWD: begin
                if (core_ready) begin
                    state_d = full_q ? S_PAD_START : S_IDLE;
                end
            end
            S_PAD_START: state_d = S_PAD_WAIT;
            S_PAD_WAIT: begin
                // pad_done may still be high from the previous message.
                if (cnt_q == '0) begin
                    if (pad_done) begin
                        state_d = S_SEND_LAST;
                    end else if (pad_waiting) begin
                        state_d = S_SEND_MID;
                    end
                end
            end
            S_SEND_MID: begin
                if (core_ready) begin
                    state_d = S_RESUME;
                end
            end
            S_RESUME: state_d = S_PAD_WAIT2;
            S_PAD_WAIT2: begin
                if (pad_done) begin
                    state_d = S_SEND_LAST;
                end
            end
            S_SEND_LAST: begin
                if (core_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        data_d  = data_q;
        bits_d  = bits_q;
        first_d = first_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    data_d = blk_data;
                    bits_d = bits_eff;
                    len_d  = len_sum;
                    full_d = blk_last && !short_w;
                end
            end
            S_FWD: begin
                if (core_ready) begin
                    first_d = 1'b0;
                    if (full_q) begin
                        bits_d = '0;
                    end
                end
            end
            S_PAD_START: cnt_d = CW'(SETTLE);
            S_PAD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SEND_MID: begin
                if (core_ready) begin
                    first_d = 1'b0;
                end
            end
            S_DONE: begin
                len_d   = '0;
                first_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        blk_ready  = 1'b0;
        pad_start  = 1'b0;
        pad_resume = 1'b0;
        core_valid = 1'b0;
        core_block = '0;
        core_first = 1'b0;
        core_last  = 1'b0;
        msg_done   = 1'b0;
        unique case (state_q)
            S_IDLE: blk_ready = 1'b1;
            S_FWD: begin
                core_valid = 1'b1;
                core_block = data_q;
                core_first = first_q;
            end
            S_PAD_START: pad_start = 1'b1;
            S_SEND_MID: begin
                core_valid = 1'b1;
                core_block = pad_padded_data;
                core_first = first_q;
            end
            S_RESUME: pad_resume = 1'b1;
            S_SEND_LAST: begin
                core_valid = 1'b1;
                core_block = pad_padded_data;
                core_first = first_q;
                core_last  = 1'b1;
            end
            S_DONE: msg_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md5_block_sched.sv
// Randomised bench for md5_block_sched with a behavioural padder and a
// message-level scoreboard of expected core blocks.
module tb_md5_block_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_last = 1'b0;
    logic [9:0]   blk_bits = '0;
    logic         pad_start, pad_resume;
    logic [511:0] pad_input_data;
    logic [63:0]  pad_input_size;
    logic [511:0] pad_padded_data;
    logic         pad_waiting, pad_done;
    logic         core_valid, core_ready;
    logic [511:0] core_block;
    logic         core_first, core_last, msg_done, err;

    int n_chk = 0;
    int n_pass = 0;

    logic [511:0] got_blk[$];
    logic [1:0]   got_fl[$];
    int rec_n = 0, res_n = 0, done_n = 0;
    int stall_idx = -1, stall_left = 0;
    int force_lat = -1;
    logic [63:0]  seen_size;

    md5_block_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_data        (blk_data),
        .blk_last        (blk_last),
        .blk_bits        (blk_bits),
        .pad_start       (pad_start),
        .pad_resume      (pad_resume),
        .pad_input_data  (pad_input_data),
        .pad_input_size  (pad_input_size),
        .pad_padded_data (pad_padded_data),
        .pad_waiting     (pad_waiting),
        .pad_done        (pad_done),
        .core_valid      (core_valid),
        .core_ready      (core_ready),
        .core_block      (core_block),
        .core_first      (core_first),
        .core_last       (core_last),
        .msg_done        (msg_done),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] keep_low(input logic [511:0] d, input int r);
        logic [511:0] v;
        v = d;
        for (int i = r; i < 512; i++) v[i] = 1'b0;
        return v;
    endfunction

    // MD5 padding of a tail holding r message bits; length bytes little-endian,
    // each byte MSB-first in stream order starting at bit 448.
    function automatic void pad_ref(input logic [511:0] d, input int r, input logic [63:0] len,
                                    output logic [511:0] b1, output logic [511:0] b2, output bit two);
        logic [511:0] lf;
        lf = '0;
        for (int k = 0; k < 8; k++)
            for (int b = 0; b < 8; b++) lf[448 + 8*k + b] = len[8*k + 7 - b];
        b1 = d;
        b1[r] = 1'b1;
        two = (r >= 448);
        if (two) b2 = lf;
        else begin
            b1 = b1 | lf;
            b2 = '0;
        end
    endfunction

    // Behavioural padder: done stays stale for the settle window after start.
    logic [511:0] pm_b1, pm_b2;
    bit pm_two;
    int pm_st, pm_cd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_st = 0;
            pad_done <= 1'b0;
            pad_waiting <= 1'b0;
            pad_padded_data <= '0;
        end else begin
            case (pm_st)
                0: if (pad_start) begin
                    pad_ref(pad_input_data, int'(pad_input_size[8:0]), pad_input_size, pm_b1, pm_b2, pm_two);
                    seen_size = pad_input_size;
                    pm_cd = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                    pm_st = 1;
                end
                1: pm_st = 2;
                2: begin
                    pad_done <= 1'b0;
                    pad_waiting <= 1'b0;
                    pm_st = 3;
                end
                3: if (pm_cd > 0) pm_cd--;
                else begin
                    pad_padded_data <= pm_b1;
                    if (pm_two) begin
                        pad_waiting <= 1'b1;
                        pm_st = 4;
                    end else begin
                        pad_done <= 1'b1;
                        pm_st = 0;
                    end
                end
                4: if (pad_resume) begin
                    pad_waiting <= 1'b0;
                    pm_cd = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                    pm_st = 5;
                end
                5: if (pm_cd > 0) pm_cd--;
                else begin
                    pad_padded_data <= pm_b2;
                    pad_done <= 1'b1;
                    pm_st = 0;
                end
                default: pm_st = 0;
            endcase
        end
    end

    // Core sink: random backpressure, optional 10-cycle stall, hold checks.
    logic [511:0] hold_blk;
    logic [1:0]   hold_fl;
    bit holding = 0;
    initial begin
        core_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (core_valid && rec_n == stall_idx && stall_left > 0) begin
                core_ready = 1'b0;
                stall_left--;
            end else core_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (pad_resume) res_n++;
            if (msg_done) done_n++;
            if (!core_valid) holding = 0;
            else begin
                if (holding) begin
                    chk("hold_blk", core_block, hold_blk);
                    chk("hold_fl", 512'({core_first, core_last}), 512'(hold_fl));
                end
                if (rec_n == stall_idx && !core_ready) chk("stall_res", 512'(pad_resume), '0);
                if (core_ready) begin
                    got_blk.push_back(core_block);
                    got_fl.push_back({core_first, core_last});
                    rec_n++;
                    holding = 0;
                end else begin
                    holding = 1;
                    hold_blk = core_block;
                    hold_fl = {core_first, core_last};
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 512'(blk_ready), 512'(1));
        chk({tag, "_ctl"}, 512'({core_valid, pad_start, pad_resume, msg_done, err, core_first, core_last}), '0);
        chk({tag, "_blk"}, core_block, '0);
        chk({tag, "_size"}, 512'(pad_input_size), '0);
        chk({tag, "_pdata"}, pad_input_data, '0);
    endtask

    task automatic send_blk(input logic [511:0] d, input logic last, input logic [9:0] bits);
        int n;
        n = 0;
        @(negedge clk);
        blk_valid = 1'b1;
        blk_data = d;
        blk_last = last;
        blk_bits = bits;
        #1;
        while (!blk_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("blk_acc", 512'(blk_ready), 512'(1));
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data = rand512();
        blk_last = 1'($urandom_range(0, 1));
        blk_bits = 10'($urandom_range(0, 511));
    endtask

    task automatic run_msg(input int nfull, input int tbits, input bit stall);
        logic [511:0] exp_q[$];
        logic [511:0] tail, b1, b2;
        logic [63:0] len;
        bit two;
        int r, n;
        got_blk.delete();
        got_fl.delete();
        rec_n = 0;
        res_n = 0;
        done_n = 0;
        seen_size = '1;
        len = 64'(nfull * 512 + tbits);
        r = tbits % 512;
        for (int i = 0; i < nfull; i++) exp_q.push_back(rand512());
        tail = rand512();
        if (tbits == 512) exp_q.push_back(tail);
        pad_ref((tbits == 512) ? '0 : keep_low(tail, r), r, len, b1, b2, two);
        stall_idx = (stall && two) ? exp_q.size() : -1;
        stall_left = 10;
        exp_q.push_back(b1);
        if (two) exp_q.push_back(b2);
        for (int i = 0; i < nfull; i++) send_blk(exp_q[i], 1'b0, 10'd512);
        send_blk(tail, 1'b1, 10'(tbits));
        n = 0;
        while (done_n == 0 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        chk("done_n", 512'(done_n), 512'(1));
        chk("nblk", 512'(got_blk.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_blk.size(); i++) begin
            chk("blk", got_blk[i], exp_q[i]);
            chk("fl", 512'(got_fl[i]), 512'({i == 0, i == exp_q.size() - 1}));
        end
        chk("resume", 512'(res_n), 512'(two));
        chk("pad_size", 512'(seen_size), 512'(len));
        chk("err", 512'(err), '0);
        stall_idx = -1;
    endtask

    task automatic reset_mid();
        int n;
        n = 0;
        rec_n = 0;
        res_n = 0;
        stall_idx = -1;
        force_lat = 6;
        send_blk(rand512(), 1'b1, 10'd448);
        while (res_n == 0 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("wait_res", 512'(res_n), 512'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        force_lat = -1;
    endtask

    initial begin
        int nf, tb, pick;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_reset("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_msg(0, 0, 0);
        chk("empty_blk", got_blk.size() > 0 ? got_blk[0] : '1, 512'(1));
        run_msg(0, 24, 0);
        run_msg(0, 448, 0);
        run_msg(2, 512, 0);
        run_msg(0, 448, 1);
        reset_mid();
        run_msg(1, 100, 0);

        for (int m = 0; m < 20; m++) begin
            nf = $urandom_range(0, 2);
            pick = $urandom_range(0, 5);
            case (pick)
                0: tb = 0;
                1: tb = 512;
                2: tb = 447;
                3: tb = 448;
                default: tb = $urandom_range(1, 511);
            endcase
            run_msg(nf, tb, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
